// File: rtl/data_sram_bridge_pkg.sv
// Shared constants for the data-side SRAM bridge.
//   - access size codes as carried on sizeM / data_size
//   - FSM state encoding of the bridge
package data_sram_bridge_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // IDLE: no access in flight
    // ADDR: request raised, waiting for the bus to accept the address
    // DATA: address accepted, waiting for the transfer to complete
    // DONE: load result held until the rest of the pipeline lets go
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/data_sram_bridge_load_extend.sv
// Load extraction unit: picks the addressed byte/half out of a 32-bit
// read word and sign- or zero-extends it. Word accesses pass through.
// Ports:
//   i_word    raw 32-bit read word
//   i_addr_lo byte offset within the word (addrM[1:0])
//   i_size    access size code (SIZE_B / SIZE_H / SIZE_W)
//   i_signed  1 = sign-extend, 0 = zero-extend
//   o_data    extended load result
module data_sram_bridge_load_extend
    import data_sram_bridge_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    // Half select uses only bit 1; a misaligned half never gets here
    // without an exception having been raised upstream.
    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = i_word;
        case (i_size)
            SIZE_B:  o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SIZE_H:  o_data = {{16{i_signed & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/data_sram_bridge.sv
// M-stage data-access bridge onto an SRAM-like bus. Issues one bus
// transaction per memory instruction, aligns store data/strobes, extends
// load data and stalls the pipeline until the access completes.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   memenM, memwriteM        M-stage memory access / store flag
//   sizeM, loadsignedM       access size, load sign-extension
//   excM                     M-stage exception, blocks a new issue
//   stall_other              pipeline held by another source
//   addrM, wdataM            byte address, LSB-justified store data
//   rdataM, stallM           extended load result, stall request
//   data_req/wr/size/addr/wstrb/wdata   bus request side
//   data_addr_ok/data_ok/rdata          bus response side
module data_sram_bridge
    import data_sram_bridge_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32   // strobe/replication logic is written for 32 bits
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memenM,
    input  logic          memwriteM,
    input  logic [1:0]    sizeM,
    input  logic          loadsignedM,
    input  logic          excM,
    input  logic          stall_other,
    input  logic [AW-1:0] addrM,
    input  logic [DW-1:0] wdataM,
    output logic [DW-1:0] rdataM,
    output logic          stallM,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [3:0]    data_wstrb,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata
);

    state_e        r_state;
    state_e        w_state_next;
    logic [DW-1:0] r_rdata;
    logic          w_start;
    logic          w_capture;

    assign w_start = memenM & ~excM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_rdata <= data_rdata;
            end
        end
    end

    // Request is raised combinationally in IDLE so a zero-wait bus can
    // accept it in the issue cycle. Once raised it is held until accepted
    // regardless of excM.
    always_comb begin
        w_state_next = r_state;
        data_req     = 1'b0;
        stallM       = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    data_req     = 1'b1;
                    stallM       = 1'b1;
                    w_state_next = data_addr_ok ? ST_DATA : ST_ADDR;
                end
            end
            ST_ADDR: begin
                data_req = 1'b1;
                stallM   = 1'b1;
                if (data_addr_ok) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                stallM = 1'b1;
                if (data_data_ok) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                // DONE: hold the result while someone else stalls, and do
                // not re-issue the same (still present) M instruction.
                if (!stall_other) begin
                    w_state_next = ST_IDLE;
                end
            end
        endcase
    end

    assign data_wr   = memwriteM;
    assign data_size = sizeM;
    assign data_addr = addrM;

    always_comb begin
        data_wdata = wdataM;
        data_wstrb = 4'b1111;
        case (sizeM)
            SIZE_B: begin
                data_wdata = {4{wdataM[7:0]}};
                data_wstrb = 4'b0001 << addrM[1:0];
            end
            SIZE_H: begin
                data_wdata = {2{wdataM[15:0]}};
                data_wstrb = addrM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                data_wdata = wdataM;
                data_wstrb = 4'b1111;
            end
        endcase
        if (!(memenM && memwriteM)) begin
            data_wstrb = 4'b0000;
        end
    end

    data_sram_bridge_load_extend u_load_extend (
        .i_word    (r_rdata),
        .i_addr_lo (addrM[1:0]),
        .i_size    (sizeM),
        .i_signed  (loadsignedM),
        .o_data    (rdataM)
    );

endmodule

// File: tb/tb_data_sram_bridge.sv
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM, memwriteM, loadsignedM, excM, stall_other;
    logic [1:0]  sizeM;
    logic [31:0] addrM, wdataM;
    logic [31:0] rdataM;
    logic        stallM, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_sram_bridge #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .memenM       (memenM),
        .memwriteM    (memwriteM),
        .sizeM        (sizeM),
        .loadsignedM  (loadsignedM),
        .excM         (excM),
        .stall_other  (stall_other),
        .addrM        (addrM),
        .wdataM       (wdataM),
        .rdataM       (rdataM),
        .stallM       (stallM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic [31:0] model_load(logic [31:0] word, logic [31:0] addr,
                                               logic [1:0] sz, bit sgn);
        longint unsigned v;
        int nbytes;
        int off;
        if (sz == 2'd2) return word;
        nbytes = (sz == 2'd0) ? 1 : 2;
        off    = int'(addr % 4) & ~(nbytes - 1);
        v = (longint'(word) >> (8 * off)) % (64'd1 << (8 * nbytes));
        if (sgn && v >= (64'd1 << (8 * nbytes - 1)))
            v = v + 64'h1_0000_0000 - (64'd1 << (8 * nbytes));
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_strb(bit wr, logic [1:0] sz, logic [31:0] addr);
        int nbytes;
        int off;
        int m;
        if (!wr) return 4'd0;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off    = int'(addr % 4) & ~(nbytes - 1);
        m      = ((1 << nbytes) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(logic [1:0] sz, logic [31:0] w);
        if (sz == 2'd0) return (w % 32'h100) * 32'h0101_0101;
        if (sz == 2'd1) return (w % 32'h1_0000) * 32'h0001_0001;
        return w;
    endfunction

    // Drive one memory instruction through its whole life:
    // address accepted a_dly cycles after issue, data_ok d_dly cycles
    // after the first DATA cycle, then `hold` extra DONE cycles.
    task automatic run_access(input string name, input bit wr, input logic [1:0] sz,
                              input bit sgn, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int a_dly, input int d_dly,
                              input int hold);
        int n_stall = 0;
        int n_req = 0;
        int n_bad_rd = 0;
        int n_stall_done = 0;
        int done_at = a_dly + 2 + d_dly;
        int total = done_at + hold + 1;
        logic [31:0] exp_rd = model_load(rd, addr, sz, sgn);
        logic [3:0]  exp_st = model_strb(wr, sz, addr);
        logic [31:0] exp_wd = model_wdata(sz, wd);
        logic [3:0]  got_st = 4'd0;
        logic [31:0] got_wd = 32'd0;
        logic        got_wr = 1'b0;
        logic [31:0] got_rd = 32'd0;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            memenM = 1'b1; memwriteM = wr; sizeM = sz; loadsignedM = sgn;
            addrM = addr; wdataM = wd; excM = 1'b0;
            data_addr_ok = (k == a_dly);
            data_data_ok = (k == a_dly + 1 + d_dly);
            data_rdata   = (k == a_dly + 1 + d_dly) ? rd : $urandom;
            stall_other  = (k >= done_at) && (k < total - 1);
            if (k >= done_at) begin
                // stray handshakes while holding the result must be ignored
                data_addr_ok = 1'($urandom_range(0, 1));
                data_data_ok = 1'($urandom_range(0, 1));
            end
            #1;
            if (stallM) n_stall++;
            if (data_req) n_req++;
            if (k == 0) begin
                got_st = data_wstrb; got_wd = data_wdata; got_wr = data_wr;
            end
            if (k >= done_at) begin
                if (stallM) n_stall_done++;
                if (!wr && rdataM !== exp_rd) begin
                    n_bad_rd++;
                    got_rd = rdataM;
                end
            end
        end
        $display("txn %s wr=%0d sz=%0d addr=%08h wd=%08h rd=%08h stall=%0d req=%0d rdataM=%08h",
                 name, wr, sz, addr, wd, rd, n_stall, n_req, rdataM);
        n_cmp++;
        if (n_stall !== done_at) begin
            n_bad++; $display("FAIL %s stall_cycles got %0d want %0d", name, n_stall, done_at);
        end
        n_cmp++;
        if (n_req !== a_dly + 1) begin
            n_bad++; $display("FAIL %s req_cycles got %0d want %0d", name, n_req, a_dly + 1);
        end
        n_cmp++;
        if (n_stall_done !== 0) begin
            n_bad++; $display("FAIL %s stall_in_done got %0d want 0", name, n_stall_done);
        end
        n_cmp++;
        if (got_st !== exp_st) begin
            n_bad++; $display("FAIL %s wstrb got %b want %b", name, got_st, exp_st);
        end
        n_cmp++;
        if (got_wr !== wr) begin
            n_bad++; $display("FAIL %s data_wr got %0d want %0d", name, got_wr, wr);
        end
        if (wr) begin
            n_cmp++;
            if (got_wd !== exp_wd) begin
                n_bad++; $display("FAIL %s wdata got %08h want %08h", name, got_wd, exp_wd);
            end
        end else begin
            n_cmp++;
            if (n_bad_rd !== 0) begin
                n_bad++;
                $display("FAIL %s rdataM got %08h want %08h (%0d cycles)",
                         name, got_rd, exp_rd, n_bad_rd);
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            memenM = 1'b0; excM = 1'b0; stall_other = 1'b0;
            data_addr_ok = 1'b0; data_data_ok = 1'b0;
            #1;
            n_cmp++;
            if (stallM !== 1'b0 || data_req !== 1'b0) begin
                n_bad++;
                $display("FAIL idle stall/req got %0d/%0d want 0/0", stallM, data_req);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        memenM = 1'b0; memwriteM = 1'b0; sizeM = 2'd2; loadsignedM = 1'b0;
        excM = 1'b0; stall_other = 1'b0; addrM = 32'h0; wdataM = 32'h0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        $display("txn reset stall=%0d req=%0d rdataM=%08h", stallM, data_req, rdataM);
        n_cmp++;
        if (stallM !== 1'b0 || data_req !== 1'b0 || rdataM !== 32'h0) begin
            n_bad++;
            $display("FAIL reset stall/req/rdata got %0d/%0d/%08h want 0/0/00000000",
                     stallM, data_req, rdataM);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_directed;
        run_access("lw_0x100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
        idle_cycles(1);
        run_access("lb_0x103", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 0);
        idle_cycles(1);
        run_access("lbu_0x103", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 0);
        idle_cycles(1);
        run_access("sh_0x202", 1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 0, 0, 0);
        idle_cycles(1);
    endtask

    task automatic test_exc;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            memenM = 1'b1; excM = 1'b1; memwriteM = 1'b0; sizeM = 2'd2;
            addrM = 32'h301; data_addr_ok = 1'($urandom_range(0, 1)); data_data_ok = 1'b0;
            #1;
            $display("txn exc cycle=%0d stall=%0d req=%0d", k, stallM, data_req);
            n_cmp++;
            if (stallM !== 1'b0 || data_req !== 1'b0) begin
                n_bad++;
                $display("FAIL exc stall/req got %0d/%0d want 0/0", stallM, data_req);
            end
        end
        // If the FSM left IDLE, this access would show the wrong latency.
        run_access("lw_after_exc", 1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 32'h0BADF00D, 0, 0, 0);
        idle_cycles(1);
    endtask

    task automatic test_wait_states;
        run_access("lh_wait", 1'b0, 2'd1, 1'b1, 32'h402, 32'h0, 32'h9ABC1234, 3, 1, 2);
        idle_cycles(1);
    endtask

    task automatic test_back_to_back;
        run_access("b2b_sw", 1'b1, 2'd2, 1'b0, 32'h500, 32'hCAFEF00D, 32'h0, 0, 0, 0);
        run_access("b2b_lh", 1'b0, 2'd1, 1'b0, 32'h506, 32'h0, 32'hF00D8001, 1, 0, 0);
        run_access("b2b_sb", 1'b1, 2'd0, 1'b0, 32'h509, 32'h000000A5, 32'h0, 0, 2, 1);
        idle_cycles(1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            bit          wr  = 1'($urandom_range(0, 1));
            logic [1:0]  sz  = 2'($urandom_range(0, 2));
            bit          sgn = 1'($urandom_range(0, 1));
            logic [31:0] ad  = $urandom;
            run_access("rand", wr, sz, sgn, ad, $urandom, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) idle_cycles(1);
        end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        memenM = 1'b1; memwriteM = 1'b0; sizeM = 2'd2; excM = 1'b0;
        addrM = 32'h600; data_addr_ok = 1'b1; data_data_ok = 1'b0; stall_other = 1'b0;
        #1;
        n_cmp++;
        if (data_req !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid issue data_req got %0d want 1", data_req);
        end
        @(negedge clk);                 // now in DATA
        data_addr_ok = 1'b0; memenM = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (stallM !== 1'b0 || rdataM !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid async stall/rdata got %0d/%08h want 0/00000000",
                     stallM, rdataM);
        end
        @(negedge clk);
        rst = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h5555AAAA;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (stallM !== 1'b0 || data_req !== 1'b0 || rdataM !== 32'h0) begin
                n_bad++;
                $display("FAIL rst_mid stray stall/req/rdata got %0d/%0d/%08h want 0/0/00000000",
                         stallM, data_req, rdataM);
            end
            @(negedge clk);
            data_data_ok = 1'b0;
            #1;
        end
        $display("txn rst_mid stall=%0d req=%0d rdataM=%08h", stallM, data_req, rdataM);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_exc();
        test_wait_states();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

Memory-stage data-access bridge that executes the loads/stores flagged by the main decoder's M-stage controls (`memenM`, `memwriteM`) over the SRAM-like data bus. It issues one bus transaction per memory instruction, aligns store data and byte strobes, sign- or zero-extends load data, and stalls the pipeline until the access completes. It sits between the M pipeline register and the data-side bus port of the CPU top.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width (fixed at 32; strobe logic assumes 4 bytes).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `memenM`  in  1  M-stage instruction accesses memory.
- `memwriteM`  in  1  access is a store (meaningful only when `memenM`=1).
- `sizeM`  in  2  access size: 0 = byte, 1 = half, 2 = word.
- `loadsignedM`  in  1  load result is sign-extended (LB, LH); 0 means zero-extend.
- `excM`  in  1  M-stage exception (including address error); blocks issue.
- `stall_other`  in  1  pipeline held by another source this cycle.
- `addrM`  in  AW  byte address.
- `wdataM`  in  DW  store data, LSB-justified.
- `rdataM`  out  DW  extended load result.
- `stallM`  out  1  stall request to hazard logic.
- `data_req`  out  1  bus request.
- `data_wr`  out  1  1 = write.
- `data_size`  out  2  equals `sizeM`.
- `data_addr`  out  AW  equals `addrM`.
- `data_wstrb`  out  4  byte enables.
- `data_wdata`  out  DW  replicated store data.
- `data_addr_ok`  in  1  bus accepted request.
- `data_data_ok`  in  1  bus completed transfer; read data valid.
- `data_rdata`  in  DW  raw read word.

## Operation
- FSM states: IDLE, ADDR (request pending), DATA (awaiting completion), DONE (result held).
- IDLE: `start` = `memenM` & ~`excM`. When `start`=1, assert `data_req` in the same cycle (Mealy) and go to DATA if `data_addr_ok`, else ADDR. When `start`=0, stay in IDLE.
- ADDR: hold `data_req`; go to DATA on `data_addr_ok`. A request is never retracted, and `excM` is ignored once the request is issued.
- DATA: on `data_data_ok`, register `data_rdata` and go to DONE.
- DONE: present the result. Go to IDLE when `stall_other`=0; otherwise hold and do not re-issue.
- `stallM` = (IDLE & `start`) | ADDR | DATA.
- In IDLE and DONE, `data_data_ok` and `data_addr_ok` are ignored.
- Store alignment:
  - Byte: wdata = 4 copies of bits [7:0]; wstrb = 0001 shifted left by `addrM`[1:0].
  - Half: wdata = 2 copies of bits [15:0]; wstrb = 1100 if `addrM`[1], else 0011.
  - Word: wdata unchanged; wstrb = 1111.
  - Loads: wstrb = 0000.
- Load extraction: select the byte at `addrM`[1:0] or the half at `addrM`[1] from the registered word, then extend according to `loadsignedM`. Word loads pass through unchanged.
- Misalignment is not checked here; it arrives as `excM`.

## Timing
- Reset values: state IDLE; `stallM` 0; `data_req` 0; read register 0; `rdataM` 0.
- `data_wr`, `data_size`, `data_addr`, `data_wstrb`, `data_wdata` are combinational from M inputs. The M inputs are stable while `stallM`=1.
- Minimum latency with `addr_ok` in cycle 0 and `data_ok` in cycle 1:
  - `stallM` high in cycles 0–1.
  - DONE in cycle 2; `rdataM` valid in cycle 2.
  - The pipeline advances at the end of cycle 2.
- Each bus wait cycle adds one stall cycle.
- `data_data_ok` in the same cycle as `data_addr_ok` is not supported by this bus; the bridge samples `data_data_ok` only in DATA.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately, and late `data_ok` responses are ignored.
- Back-to-back accesses: DONE→IDLE, then the next instruction issues in the following cycle.

## Structure
- Constants belong in `defines.vh`: size codes (`SIZE_B`, `SIZE_H`, `SIZE_W`) and FSM state encoding.
- One combinational sub-module, `load_extend`, holds the byte/half selection and extension.

## Test plan
- LW at 0x100 with `addr_ok` and `data_ok` on consecutive cycles, `data_rdata`=0xDEADBEEF → `stallM` high 2 cycles; `rdataM`=0xDEADBEEF in DONE.
- LB at 0x103, signed, `data_rdata`=0x80FFFFFF → `rdataM`=0xFFFFFF80. LBU on the same data → `rdataM`=0x00000080.
- SH at 0x202 with `wdataM`=0x1234ABCD → `data_wstrb`=1100, `data_wdata`=0xABCDABCD, `data_wr`=1.
- `excM`=1 together with `memenM` → `data_req` stays 0, `stallM` stays 0, state stays IDLE.
- `addr_ok` delayed 3 cycles, then `data_ok` after 2 more cycles, with `stall_other`=1 for 2 cycles after completion → `stallM` high 6 cycles; DONE holds `rdataM` for 3 cycles; no second `data_req`.
- `rst` pulsed while in DATA, followed by a stray `data_ok` → FSM in IDLE; `stallM`=0; `rdataM`=0.
